// File: rtl/gcd_control.sv
// gcd_control: FSM controller for the subtractive-GCD datapath.
//
// Wraps the datapath in a valid/ready request/response handshake. An accepted
// request loads inA/inB into the datapath A/B registers. The controller then
// repeatedly swaps (A < B) or subtracts (A := A - B) until B == 0, and finally
// presents the result sitting on the datapath vout until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_val    upstream: operands valid on datapath inA/inB
//   req_rdy    upstream: controller can accept a request (IDLE)
//   resp_val   downstream: result valid on datapath vout (DONE)
//   resp_rdy   downstream: consumer accepts result
//   zero       datapath status, B == 0
//   lt         datapath status, A < B
//   mux_sel_A  00=inA, 01=B, 10=A-B, 11=hold A
//   mux_sel_B  0=inB, 1=A
//   A_reg_en   datapath A register load enable
//   B_reg_en   datapath B register load enable
//   cycles     (only with GCD_CYCLE_CNT_EN) saturating count of CALC cycles
//              of the most recent request
//
// Optional feature macro: GCD_CYCLE_CNT_EN adds the cycles output and its
// counter. Without it the port and the counter are absent.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for req_val; req_rdy=1; accept loads operands
//   CALC   | one swap, subtract or zero-detect step per cycle
//   DONE   | result held on vout; resp_val=1 until resp_rdy

module gcd_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_val,
    output logic             req_rdy,
    output logic             resp_val,
    input  logic             resp_rdy,
    input  logic             zero,
    input  logic             lt,
    output logic [1:0]       mux_sel_A,
    output logic             mux_sel_B,
    output logic             A_reg_en,
`ifdef GCD_CYCLE_CNT_EN
    output logic             B_reg_en,
    output logic [CNT_W-1:0] cycles
`else
    output logic             B_reg_en
`endif
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mux_sel_A = 2'b11;
        mux_sel_B = 1'b0;
        A_reg_en  = 1'b0;
        B_reg_en  = 1'b0;
        req_rdy   = 1'b0;
        resp_val  = 1'b0;

        case (r_state)
            S_IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    mux_sel_A = 2'b00;
                    mux_sel_B = 1'b0;
                    A_reg_en  = 1'b1;
                    B_reg_en  = 1'b1;
                    w_next    = S_CALC;
                end
            end
            S_CALC: begin
                // zero and lt are never both set (B == 0 means A < B is false),
                // so checking lt first is enough.
                if (lt) begin
                    mux_sel_A = 2'b01;
                    mux_sel_B = 1'b1;
                    A_reg_en  = 1'b1;
                    B_reg_en  = 1'b1;
                end else if (!zero) begin
                    mux_sel_A = 2'b10;
                    A_reg_en  = 1'b1;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // While reset is held the datapath must not load, whatever req_val does.
        if (!rst_n) begin
            mux_sel_A = 2'b11;
            mux_sel_B = 1'b0;
            A_reg_en  = 1'b0;
            B_reg_en  = 1'b0;
            req_rdy   = 1'b1;
            resp_val  = 1'b0;
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if ((r_state == S_IDLE) && req_val) begin
            r_cycles <= '0;
        end else if ((r_state == S_CALC) && !(&r_cycles)) begin
            r_cycles <= r_cycles + CNT_W'(1);
        end
    end

    assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_gcd_control.sv
module tb_gcd_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_val = 1'b0;
    logic        resp_rdy = 1'b1;
    logic        req_rdy;
    logic        resp_val;
    logic        zero;
    logic        lt;
    logic [1:0]  mux_sel_A;
    logic        mux_sel_B;
    logic        A_reg_en;
    logic        B_reg_en;
`ifdef GCD_CYCLE_CNT_EN
    logic [15:0] cycles;
`endif

    // Behavioural datapath attached to the controller.
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] dp_a = '0;
    logic [15:0] dp_b = '0;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_accepts = 0;
    int n_resp    = 0;
    logic prev_resp = 1'b0;

    always #5 clk = ~clk;

    gcd_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .zero      (zero),
        .lt        (lt),
        .mux_sel_A (mux_sel_A),
        .mux_sel_B (mux_sel_B),
        .A_reg_en  (A_reg_en),
`ifdef GCD_CYCLE_CNT_EN
        .B_reg_en  (B_reg_en),
        .cycles    (cycles)
`else
        .B_reg_en  (B_reg_en)
`endif
    );

    always @(posedge clk) begin
        if (A_reg_en) begin
            case (mux_sel_A)
                2'b00:   dp_a <= in_a;
                2'b01:   dp_a <= dp_b;
                2'b10:   dp_a <= dp_a - dp_b;
                default: dp_a <= dp_a;
            endcase
        end
        if (B_reg_en) dp_b <= mux_sel_B ? dp_a : in_b;
    end

    assign zero = (dp_b == 16'd0);
    assign lt   = (dp_a < dp_b);

    // Count rising edges of resp_val to prove one response per accept.
    always @(negedge clk) begin
        prev_resp <= resp_val;
        if (resp_val && !prev_resp) n_resp <= n_resp + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: Euclid for the result.
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Reference: number of step cycles of the subtractive algorithm
    // (swap if a<b, else subtract if b!=0, else the final detect step).
    function automatic int ref_steps(input int a, input int b);
        int n = 0;
        int t;
        for (int k = 0; k < 100000; k++) begin
            n++;
            if (a < b) begin
                t = a; a = b; b = t;
            end else if (b != 0) begin
                a = a - b;
            end else begin
                return n;
            end
        end
        return -1;
    endfunction

    task automatic run_gcd(input int a, input int b, input int stall, input bit keep);
        int g, n, lat, w;
        bit calc_bad;
        g = ref_gcd(a, b);
        n = ref_steps(a, b);
        w = 0;
        while (!req_rdy && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("req_rdy_before_req", {31'd0, req_rdy}, 32'd1);
        in_a     = a[15:0];
        in_b     = b[15:0];
        req_val  = 1'b1;
        resp_rdy = (stall == 0);
        @(posedge clk); #1;
        n_accepts++;
        if (keep) begin
            // Junk operands while busy must be ignored.
            in_a = 16'($urandom_range(0, 255));
            in_b = 16'($urandom_range(0, 255));
        end else begin
            req_val = 1'b0;
        end
        lat = 0;
        calc_bad = 1'b0;
        while (!resp_val && lat < 1000) begin
            if (req_rdy) calc_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check_val("calc_req_rdy_low", {31'd0, calc_bad}, 32'd0);
        check_val("latency", lat, n);
        check_val("vout", {16'd0, dp_a}, g);
`ifdef GCD_CYCLE_CNT_EN
        check_val("cycles", {16'd0, cycles}, n);
`endif
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_val("stall_resp_val", {31'd0, resp_val}, 32'd1);
            check_val("stall_vout", {16'd0, dp_a}, g);
            check_val("stall_req_rdy", {31'd0, req_rdy}, 32'd0);
            check_val("stall_en", {30'd0, A_reg_en, B_reg_en}, 32'd0);
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        check_val("resp_one_cycle", {31'd0, resp_val}, 32'd0);
        check_val("back_to_idle", {31'd0, req_rdy}, 32'd1);
`ifdef GCD_CYCLE_CNT_EN
        check_val("cycles_hold", {16'd0, cycles}, n);
`endif
    endtask

    initial begin
        // Reset held with req_val high: nothing may load.
        rst_n   = 1'b0;
        req_val = 1'b1;
        in_a    = 16'd5;
        in_b    = 16'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
            check_val("rst_resp_val", {31'd0, resp_val}, 32'd0);
            check_val("rst_en", {30'd0, A_reg_en, B_reg_en}, 32'd0);
            check_val("rst_mux_a", {30'd0, mux_sel_A}, 32'd3);
            check_val("rst_mux_b", {31'd0, mux_sel_B}, 32'd0);
        end
        req_val = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("idle_req_rdy", {31'd0, req_rdy}, 32'd1);
            check_val("idle_resp_val", {31'd0, resp_val}, 32'd0);
            check_val("idle_en", {30'd0, A_reg_en, B_reg_en}, 32'd0);
        end

        run_gcd(27, 15, 0, 1'b0);
        run_gcd(5, 0, 0, 1'b0);
        run_gcd(0, 7, 0, 1'b0);
        run_gcd(0, 0, 0, 1'b0);
        run_gcd(9, 9, 0, 1'b0);
        run_gcd(12, 8, 5, 1'b0);

        // Reset during the third CALC cycle of GCD(27,15).
        in_a = 16'd27;
        in_b = 16'd15;
        req_val = 1'b1;
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_resp_val", {31'd0, resp_val}, 32'd0);
        check_val("midrst_en", {30'd0, A_reg_en, B_reg_en}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_val("midrst_req_rdy", {31'd0, req_rdy}, 32'd1);
        run_gcd(14, 21, 0, 1'b0);

        // req_val held high across two requests.
        run_gcd(18, 12, 0, 1'b1);
        run_gcd(7, 5, 0, 1'b1);
        req_val = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_gcd(int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
                    int'($urandom_range(0, 2)), 1'b0);
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        check_val("resp_per_accept", n_resp, n_accepts);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
